braille_decoder: RTL and testbench
==================================

// Module: braille_decoder
// PURPOSE
//   Receives 6-dot braille cells (same dot encoding as led_out of the converter) and decodes
//   them to 8-bit ASCII. Inverse path of the text-to-braille converter; feeds a
//   character sink or loopback checker. Handles capital and number prefix cells internally.
// PARAMETERS
//   UNKNOWN_CHAR  8'h3F      ASCII emitted for an undecodable cell ('?')
//   CAP_CELL      6'b100000  capital-sign cell (dot 6)
//   NUM_CELL      6'b111100  number-sign cell (dots 3,4,5,6)
//   CNT_W         16         width of char_count
// PORTS
//   clk         in   1      system clock, rising edge
//   reset       in   1      asynchronous, active-low reset
//   cell_in     in   6      braille cell; bit0=dot1 ... bit5=dot6
//   cell_valid  in   1      cell_in valid
//   cell_ready  out  1      decoder can accept a cell this cycle
//   char_out    out  8      decoded ASCII character
//   char_valid  out  1      char_out valid; held until char_ready
//   char_ready  in   1      sink accepts char_out
//   err         out  1      one-cycle pulse: undecodable cell consumed
//   char_count  out  CNT_W  characters delivered (char_valid&char_ready); wraps at 2^CNT_W
// BEHAVIOUR
//   Reset (reset=0, async): cell_ready=0, char_out=0, char_valid=0, err=0, char_count=0,
//     cap_once=0, caps_lock=0, num_mode=0, state=IDLE. cell_ready rises 1 cycle after release.
//   Handshake: cell transfer when cell_valid&cell_ready; char transfer when char_valid&char_ready.
//     cell_ready = (state==IDLE) & ~char_valid. char_out stable while char_valid&~char_ready.
//   States: IDLE -> DECODE on cell transfer; DECODE -> OUT if cell yields a char, else IDLE;
//     OUT -> IDLE on char transfer. Cell accepted in cycle N -> char_valid asserted in N+2.
//   Decode table (letters): a=000001 b=000011 c=001001 d=011001 e=010001 f=001011
//     g=011011 h=010011 i=001010 j=011010; k..t = a..j with bit2 set;
//     u,v,x,y,z = a,b,c,d,e with bits2,5 set; w=111010; space=000000 -> 8'h20.
//   Prefixes (no char emitted): CAP_CELL with cap_once=0 -> cap_once=1; CAP_CELL with
//     cap_once=1 -> caps_lock=1, cap_once=0; NUM_CELL -> num_mode=1.
//   num_mode=1: cells a..j -> '1'..'9','0' (j->'0'); cap flags ignored and left unchanged.
//   Letter, num_mode=0: uppercase (subtract 8'h20) if cap_once|caps_lock; cap_once cleared.
//   Space: emits 8'h20, clears num_mode, caps_lock, cap_once.
//   Other cells (incl. non-digit letter in num_mode): emit UNKNOWN_CHAR, err=1 in DECODE cycle,
//     clear num_mode and cap_once.
//   char_count increments by 1 on each char transfer; wraps to 0 after all-ones.
//   Reset mid-operation: any pending char discarded, all mode flags cleared immediately.
// TESTING
//   1. reset low 3 cycles, char_ready=1; send 000011 -> char_out=8'h62 ('b'), err=0, count=1.
//   2. send 100000,000001,000001 -> 'A' then 'a'; cap_once cleared after one letter.
//   3. send 100000,100000,000011,000001,000000,000001 -> 'B','A',8'h20,'a' (caps lock ends at space).
//   4. send 111100,000001,011010,000000,000001 -> '1','0',' ','a'; num_mode cleared by space.
//   5. send 111111 -> char_out=8'h3F, err pulses once; then 000001 -> 'a'.
//   6. char_ready=0 for 10 cycles with char pending -> char_out stable, cell_ready=0; then
//      release -> single transfer, count+1; assert reset mid-OUT -> char_valid=0 async, count=0.

Source files
------------

// File: rtl/braille_decoder.sv
// Braille cell to ASCII decoder with capital/number prefix handling.
// One cell is decoded per transaction; prefix cells only update mode flags.
module braille_decoder #(
  parameter logic [7:0]  UNKNOWN_CHAR = 8'h3F,
  parameter logic [5:0]  CAP_CELL     = 6'b100000,
  parameter logic [5:0]  NUM_CELL     = 6'b111100,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       cell_in,
  input  logic             cell_valid,
  output logic             cell_ready,
  output logic [7:0]       char_out,
  output logic             char_valid,
  input  logic             char_ready,
  output logic             err,
  output logic [CNT_W-1:0] char_count
);

  // state  | meaning
  // IDLE   | waiting for a cell; cell_ready high when no char pending
  // DECODE | cell consumed and decoded; err pulses here for bad cells
  // OUT    | char_out presented, waiting for char_ready
  typedef enum logic [1:0] {IDLE, DECODE, OUT} state_t;

  state_t           state_q, state_d;
  logic             cell_ready_q, cell_ready_d;
  logic [7:0]       char_out_q, char_out_d;
  logic             char_valid_q, char_valid_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             cap_once_q, cap_once_d;
  logic             caps_lock_q, caps_lock_d;
  logic             num_mode_q, num_mode_d;
  logic             emit_q, emit_d;

  // Returns {valid, index 0..9} for the a..j dot patterns.
  function automatic logic [4:0] base_idx(input logic [5:0] c);
    case (c)
      6'b000001: base_idx = 5'h10;
      6'b000011: base_idx = 5'h11;
      6'b001001: base_idx = 5'h12;
      6'b011001: base_idx = 5'h13;
      6'b010001: base_idx = 5'h14;
      6'b001011: base_idx = 5'h15;
      6'b011011: base_idx = 5'h16;
      6'b010011: base_idx = 5'h17;
      6'b001010: base_idx = 5'h18;
      6'b011010: base_idx = 5'h19;
      default:   base_idx = 5'h00;
    endcase
  endfunction

  logic [4:0] base;
  logic [4:0] letter_idx;
  logic       is_letter;
  logic       is_digit;
  logic [7:0] lower_ch;
  logic [7:0] digit_ch;

  always_comb begin
    base       = base_idx(cell_in & 6'b011011);
    letter_idx = 5'd0;
    is_letter  = 1'b0;
    is_digit   = 1'b0;
    if (cell_in == 6'b111010) begin
      is_letter  = 1'b1;
      letter_idx = 5'd22;
    end else if (base[4]) begin
      // bit2 selects k..t, bits2+5 select the u..z row (w is irregular)
      unique case ({cell_in[5], cell_in[2]})
        2'b00: begin
          is_letter  = 1'b1;
          is_digit   = 1'b1;
          letter_idx = {1'b0, base[3:0]};
        end
        2'b01: begin
          is_letter  = 1'b1;
          letter_idx = 5'd10 + {1'b0, base[3:0]};
        end
        2'b11: begin
          if (base[3:0] < 4'd5) begin
            is_letter  = 1'b1;
            letter_idx = (base[3:0] < 4'd2) ? 5'd20 + {1'b0, base[3:0]}
                                            : 5'd21 + {1'b0, base[3:0]};
          end
        end
        default: ;
      endcase
    end
    lower_ch = 8'h61 + {3'b000, letter_idx};
    digit_ch = (base[3:0] == 4'd9) ? 8'h30 : 8'h31 + {4'b0000, base[3:0]};
  end

  always_comb begin
    state_d      = state_q;
    char_out_d   = char_out_q;
    char_valid_d = char_valid_q;
    err_d        = 1'b0;
    count_d      = count_q;
    cap_once_d   = cap_once_q;
    caps_lock_d  = caps_lock_q;
    num_mode_d   = num_mode_q;
    emit_d       = emit_q;
    case (state_q)
      IDLE: begin
        if (cell_valid && cell_ready_q) begin
          state_d = DECODE;
          emit_d  = 1'b1;
          if (cell_in == CAP_CELL) begin
            emit_d = 1'b0;
            if (cap_once_q) begin
              caps_lock_d = 1'b1;
              cap_once_d  = 1'b0;
            end else begin
              cap_once_d = 1'b1;
            end
          end else if (cell_in == NUM_CELL) begin
            emit_d     = 1'b0;
            num_mode_d = 1'b1;
          end else if (cell_in == 6'b000000) begin
            char_out_d  = 8'h20;
            num_mode_d  = 1'b0;
            caps_lock_d = 1'b0;
            cap_once_d  = 1'b0;
          end else if (num_mode_q && is_digit) begin
            char_out_d = digit_ch;
          end else if (!num_mode_q && is_letter) begin
            char_out_d = (cap_once_q || caps_lock_q) ? lower_ch - 8'h20 : lower_ch;
            cap_once_d = 1'b0;
          end else begin
            char_out_d = UNKNOWN_CHAR;
            err_d      = 1'b1;
            num_mode_d = 1'b0;
            cap_once_d = 1'b0;
          end
        end
      end
      DECODE: begin
        state_d      = emit_q ? OUT : IDLE;
        char_valid_d = emit_q;
      end
      OUT: begin
        if (char_ready) begin
          char_valid_d = 1'b0;
          count_d      = count_q + CNT_W'(1);
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    cell_ready_d = (state_d == IDLE) && !char_valid_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      cell_ready_q <= 1'b0;
      char_out_q   <= 8'h00;
      char_valid_q <= 1'b0;
      err_q        <= 1'b0;
      count_q      <= '0;
      cap_once_q   <= 1'b0;
      caps_lock_q  <= 1'b0;
      num_mode_q   <= 1'b0;
      emit_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cell_ready_q <= cell_ready_d;
      char_out_q   <= char_out_d;
      char_valid_q <= char_valid_d;
      err_q        <= err_d;
      count_q      <= count_d;
      cap_once_q   <= cap_once_d;
      caps_lock_q  <= caps_lock_d;
      num_mode_q   <= num_mode_d;
      emit_q       <= emit_d;
    end
  end

  assign cell_ready = cell_ready_q;
  assign char_out   = char_out_q;
  assign char_valid = char_valid_q;
  assign err        = err_q;
  assign char_count = count_q;

endmodule

// File: tb/tb_braille_decoder.sv
// Bench for braille_decoder: directed scenarios plus random cells against a table-driven model.
module tb_braille_decoder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [5:0]  cell_in = 6'd0;
  logic        cell_valid = 1'b0;
  logic        cell_ready, cell_ready_w;
  logic [7:0]  char_out, char_out_w;
  logic        char_valid, char_valid_w;
  logic        char_ready = 1'b1;
  logic        err, err_w;
  logic [15:0] char_count;
  logic [2:0]  char_count_w;

  braille_decoder dut (
    .clk(clk), .reset(reset), .cell_in(cell_in), .cell_valid(cell_valid),
    .cell_ready(cell_ready), .char_out(char_out), .char_valid(char_valid),
    .char_ready(char_ready), .err(err), .char_count(char_count)
  );

  // Narrow counter copy so the wrap-around is reachable in a short run.
  braille_decoder #(.CNT_W(3)) dut_w (
    .clk(clk), .reset(reset), .cell_in(cell_in), .cell_valid(cell_valid),
    .cell_ready(cell_ready_w), .char_out(char_out_w), .char_valid(char_valid_w),
    .char_ready(char_ready), .err(err_w), .char_count(char_count_w)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int exp_count = 0;

  localparam logic [5:0] LETTERS [26] = '{
    6'b000001, 6'b000011, 6'b001001, 6'b011001, 6'b010001, 6'b001011, 6'b011011,
    6'b010011, 6'b001010, 6'b011010, 6'b000101, 6'b000111, 6'b001101, 6'b011101,
    6'b010101, 6'b001111, 6'b011111, 6'b010111, 6'b001110, 6'b011110, 6'b100101,
    6'b100111, 6'b111010, 6'b101101, 6'b111101, 6'b110101};

  bit m_cap_once, m_caps_lock, m_num;

  function automatic int letter_of(input logic [5:0] c);
    for (int i = 0; i < 26; i++) if (LETTERS[i] == c) return i;
    return -1;
  endfunction

  task automatic model_step(input logic [5:0] c, output bit emit, output logic [7:0] ch,
                            output bit e);
    int li;
    li = letter_of(c);
    emit = 1'b1; e = 1'b0; ch = 8'h00;
    if (c == 6'b100000) begin
      emit = 1'b0;
      if (m_cap_once) begin m_caps_lock = 1'b1; m_cap_once = 1'b0; end
      else m_cap_once = 1'b1;
    end else if (c == 6'b111100) begin
      emit = 1'b0; m_num = 1'b1;
    end else if (c == 6'b000000) begin
      ch = " "; m_num = 1'b0; m_caps_lock = 1'b0; m_cap_once = 1'b0;
    end else if (m_num && li >= 0 && li < 10) begin
      ch = (li == 9) ? "0" : 8'(int'("1") + li);
    end else if (!m_num && li >= 0) begin
      ch = 8'(int'("a") + li - ((m_cap_once || m_caps_lock) ? 32 : 0));
      m_cap_once = 1'b0;
    end else begin
      ch = 8'h3F; e = 1'b1; m_num = 1'b0; m_cap_once = 1'b0;
    end
  endtask

  bit         r_timeout, r_got;
  logic [7:0] r_ch;
  int         r_errs, r_lat;

  // Drives one cell and watches for the resulting char; transfers it if do_xfer.
  task automatic run_cell(input logic [5:0] c, input bit expect_char, input bit do_xfer);
    int k;
    r_timeout = 1'b0; r_got = 1'b0; r_errs = 0; r_lat = 0; r_ch = 8'h00;
    cell_in = c; cell_valid = 1'b1;
    k = 0;
    while (!cell_ready && k < 20) begin @(posedge clk); #1; k++; end
    if (!cell_ready) begin r_timeout = 1'b1; cell_valid = 1'b0; return; end
    @(posedge clk); #1;
    cell_valid = 1'b0;
    r_lat = 1;
    r_errs += int'(err);
    for (int j = 0; j < (expect_char ? 10 : 3); j++) begin
      if (char_valid) begin r_got = 1'b1; break; end
      @(posedge clk); #1;
      r_lat++;
      if (!char_valid) r_errs += int'(err);
    end
    if (char_valid) r_got = 1'b1;
    r_ch = char_out;
    if (r_got && do_xfer) begin @(posedge clk); #1; end
  endtask

  task automatic model_clear();
    m_cap_once = 1'b0; m_caps_lock = 1'b0; m_num = 1'b0; exp_count = 0;
  endtask

  task automatic test_reset();
    reset = 1'b0; char_ready = 1'b1; cell_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    checks++;
    if ({cell_ready, char_valid, err, char_out, char_count} !== 27'd0) begin
      errors++;
      $display("FAIL reset_outputs got rdy=%b cv=%b err=%b ch=%h cnt=%0d want all zero",
               cell_ready, char_valid, err, char_out, char_count);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (cell_ready !== 1'b0) begin errors++; $display("FAIL reset_release_ready got %b want 0", cell_ready); end
    @(posedge clk); #1;
    checks++;
    if (cell_ready !== 1'b1) begin errors++; $display("FAIL ready_after_release got %b want 1", cell_ready); end
    model_clear();
  endtask

  task automatic test_basic();
    run_cell(6'b000011, 1'b1, 1'b1);
    exp_count++;
    checks++;
    if (r_timeout || !r_got || r_ch !== 8'h62) begin
      errors++; $display("FAIL basic_char got %h (got=%b) want 62", r_ch, r_got);
    end
    checks++;
    if (r_lat !== 2) begin errors++; $display("FAIL basic_latency got %0d want 2", r_lat); end
    checks++;
    if (r_errs !== 0) begin errors++; $display("FAIL basic_err got %0d want 0", r_errs); end
    checks++;
    if (char_count !== 16'd1) begin errors++; $display("FAIL basic_count got %0d want 1", char_count); end
  endtask

  // Runs a directed cell list; expected chars given with 8'hFF for "no char".
  task automatic run_seq(input string name, input logic [5:0] cells [8], input logic [7:0] exp [8],
                         input int n);
    bit e_emit, e_err;
    logic [7:0] e_ch;
    for (int i = 0; i < n; i++) begin
      model_step(cells[i], e_emit, e_ch, e_err);
      run_cell(cells[i], exp[i] != 8'hFF, 1'b1);
      if (exp[i] != 8'hFF) exp_count++;
      checks++;
      if (r_timeout || r_got !== (exp[i] != 8'hFF) || (r_got && r_ch !== exp[i])) begin
        errors++;
        $display("FAIL %s[%0d] got char=%h valid=%b want %h", name, i, r_ch, r_got, exp[i]);
      end
    end
    checks++;
    if (char_count !== 16'(exp_count)) begin
      errors++; $display("FAIL %s_count got %0d want %0d", name, char_count, exp_count);
    end
  endtask

  task automatic test_caps();
    logic [5:0] c [8];
    logic [7:0] x [8];
    c = '{6'b100000, 6'b000001, 6'b000001, 0, 0, 0, 0, 0};
    x = '{8'hFF, "A", "a", 0, 0, 0, 0, 0};
    run_seq("caps_once", c, x, 3);
  endtask

  task automatic test_caps_lock();
    logic [5:0] c [8];
    logic [7:0] x [8];
    c = '{6'b100000, 6'b100000, 6'b000011, 6'b000001, 6'b000000, 6'b000001, 0, 0};
    x = '{8'hFF, 8'hFF, "B", "A", 8'h20, "a", 0, 0};
    run_seq("caps_lock", c, x, 6);
  endtask

  task automatic test_numbers();
    logic [5:0] c [8];
    logic [7:0] x [8];
    c = '{6'b111100, 6'b000001, 6'b011010, 6'b000000, 6'b000001, 0, 0, 0};
    x = '{8'hFF, "1", "0", " ", "a", 0, 0, 0};
    run_seq("numbers", c, x, 5);
  endtask

  task automatic test_unknown();
    bit e_emit, e_err;
    logic [7:0] e_ch;
    model_step(6'b111111, e_emit, e_ch, e_err);
    run_cell(6'b111111, 1'b1, 1'b1);
    exp_count++;
    checks++;
    if (r_timeout || !r_got || r_ch !== 8'h3F) begin
      errors++; $display("FAIL unknown_char got %h want 3f", r_ch);
    end
    checks++;
    if (r_errs !== 1) begin errors++; $display("FAIL unknown_err_pulses got %0d want 1", r_errs); end
    model_step(6'b000001, e_emit, e_ch, e_err);
    run_cell(6'b000001, 1'b1, 1'b1);
    exp_count++;
    checks++;
    if (r_ch !== 8'h61 || r_errs !== 0) begin
      errors++; $display("FAIL unknown_recover got %h err=%0d want 61 err=0", r_ch, r_errs);
    end
  endtask

  task automatic test_backpressure();
    bit e_emit, e_err;
    logic [7:0] e_ch;
    char_ready = 1'b0;
    model_step(6'b000001, e_emit, e_ch, e_err);
    run_cell(6'b000001, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (char_valid !== 1'b1 || char_out !== 8'h61 || cell_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall[%0d] got cv=%b ch=%h rdy=%b want 1 61 0", i, char_valid, char_out, cell_ready);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (char_count !== 16'(exp_count)) begin
      errors++; $display("FAIL stall_count got %0d want %0d", char_count, exp_count);
    end
    char_ready = 1'b1;
    @(posedge clk); #1;
    exp_count++;
    @(posedge clk); #1;
    checks++;
    if (char_valid !== 1'b0 || char_count !== 16'(exp_count)) begin
      errors++; $display("FAIL release_single got cv=%b cnt=%0d want 0 %0d", char_valid, char_count, exp_count);
    end
    // Leave num_mode set with a char pending, then reset in OUT.
    char_ready = 1'b0;
    run_cell(6'b111100, 1'b0, 1'b0);
    run_cell(6'b000001, 1'b1, 1'b0);
    #2 reset = 1'b0;
    #1;
    checks++;
    if (char_valid !== 1'b0 || char_count !== 16'd0) begin
      errors++; $display("FAIL async_reset got cv=%b cnt=%0d want 0 0", char_valid, char_count);
    end
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b1;
    model_clear();
    char_ready = 1'b1;
    @(posedge clk); #1;
    run_cell(6'b000001, 1'b1, 1'b1);
    exp_count++;
    checks++;
    if (r_ch !== 8'h61) begin errors++; $display("FAIL reset_clears_num got %h want 61", r_ch); end
  endtask

  task automatic test_random();
    bit e_emit, e_err;
    logic [7:0] e_ch;
    logic [5:0] c;
    int sel, stall;
    for (int it = 0; it < 150; it++) begin
      sel = $urandom_range(0, 9);
      if (sel <= 5) c = LETTERS[$urandom_range(0, 25)];
      else if (sel == 6) c = 6'b100000;
      else if (sel == 7) c = 6'b111100;
      else if (sel == 8) c = 6'b000000;
      else c = 6'($urandom);
      model_step(c, e_emit, e_ch, e_err);
      stall = $urandom_range(0, 3);
      char_ready = (stall == 0);
      run_cell(c, e_emit, 1'b0);
      checks++;
      if (r_timeout || r_got !== e_emit || (e_emit && r_ch !== e_ch) || r_errs !== int'(e_err)) begin
        errors++;
        $display("FAIL rand[%0d] cell=%b got v=%b ch=%h err=%0d want v=%b ch=%h err=%0d",
                 it, c, r_got, r_ch, r_errs, e_emit, e_ch, e_err);
      end
      if (r_got) begin
        repeat (stall) begin
          @(posedge clk); #1;
          checks++;
          if (char_valid !== 1'b1 || char_out !== r_ch) begin
            errors++; $display("FAIL rand_hold[%0d] got cv=%b ch=%h want 1 %h", it, char_valid, char_out, r_ch);
          end
        end
        char_ready = 1'b1;
        @(posedge clk); #1;
        exp_count++;
      end
      char_ready = 1'b1;
      checks++;
      if (char_count !== 16'(exp_count) || char_count_w !== 3'(exp_count)) begin
        errors++;
        $display("FAIL rand_count[%0d] got %0d/%0d want %0d/%0d", it, char_count, char_count_w,
                 exp_count, exp_count % 8);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_caps();
    test_caps_lock();
    test_numbers();
    test_unknown();
    test_backpressure();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
